sfifo_mp: RTL
=============

SFIFO_MP -- requirements
Module: sfifo_mp

Interface
- REQ-001 Parameter FW, default 32: depth in entries; SHALL be a power of two and >= 2*NP.
- REQ-002 Parameter DW, default 47: width of one entry in bits.
- REQ-003 Parameter NP, default 2: lanes per side; SHALL be 1, 2 or 4.
- REQ-004 Parameter AFULL, default FW-NP: almost-full threshold in entries, range 1..FW.
- REQ-005 i_clk  in  1  sole clock; all state changes on its rising edge.
- REQ-006 i_reset  in  1  reset; synchronous, active-high.
- REQ-007 i_flush  in  1  discard all stored entries.
- REQ-008 i_wr_en  in  NP  per-lane write request; SHALL be thermometer-coded from lane 0 (lane k set implies lanes 0..k-1 set).
- REQ-009 i_wr_data  in  NP*DW  lane k occupies bits [k*DW +: DW].
- REQ-010 o_wr_ack  out  1  write group accepted this cycle.
- REQ-011 i_rd_cnt  in  $clog2(NP)+1  number of entries to pop this cycle (0..NP).
- REQ-012 o_rd_valid  out  NP  lane k holds a valid entry.
- REQ-013 o_rd_data  out  NP*DW  lane k = entry at read_ptr+k.
- REQ-014 o_count  out  $clog2(FW)+1  current occupancy.
- REQ-015 o_empty / o_full / o_afull  out  1 each  count==0 / count==FW / count>=AFULL.

Function
- REQ-016 Pointers SHALL be $clog2(FW)+1 bits wide; the MSB is the wrap bit; the index is pointer mod FW; all pointer arithmetic SHALL wrap modulo 2*FW.
- REQ-017 Let W = popcount(i_wr_en). A write group SHALL be accepted only if W>0, FW-count>=W, i_reset=0 and i_flush=0 (all-or-nothing); a group that fails this SHALL write no entries.
- REQ-018 On acceptance, lane k SHALL write entry write_ptr+k for k<W, and write_ptr SHALL advance by W.
- REQ-019 o_wr_ack SHALL be combinational and equal to the acceptance condition of REQ-017.
- REQ-020 o_rd_valid[k] SHALL equal (count>k); o_rd_data SHALL be read combinationally from storage.
- REQ-021 Pops SHALL be clamped: read_ptr advances by min(i_rd_cnt, count) when i_reset=0 and i_flush=0.
- REQ-022 Simultaneous accepted write and pop SHALL update count by W minus pops in one cycle; acceptance SHALL use the count from the start of the cycle, with no credit for same-cycle pops.
- REQ-023 Written data SHALL appear on o_rd_data no earlier than the cycle after the write; there is no write-to-read bypass when empty.
- REQ-024 i_flush SHALL set read_ptr=write_ptr=0 at the next edge; it has priority over any same-cycle write or pop.
- REQ-025 o_count, o_empty, o_full and o_afull SHALL be derived combinationally from the registered pointers only.

Reset
- REQ-026 On i_reset at a clock edge, read_ptr and write_ptr SHALL become 0, giving o_count=0, o_empty=1, o_full=0, o_afull=0 and o_rd_valid=0.
- REQ-027 Reset SHALL override flush, writes and pops asserted in the same cycle; reset asserted mid-operation SHALL discard all contents.
- REQ-028 Storage SHALL be initialised to 0 at elaboration and SHALL NOT be cleared by reset.

Configuration
- REQ-029 With macro SFIFO_ERR_EN defined, the ports o_overflow (out, 1) and o_underflow (out, 1) SHALL exist; both are sticky, registered, reset to 0 and cleared only by i_reset.
- REQ-030 o_overflow SHALL set when W>0 and the group is rejected for lack of space; o_underflow SHALL set when i_rd_cnt>count; neither sets during a reset or flush cycle.
- REQ-031 Without SFIFO_ERR_EN the ports SHALL be absent and the remaining behaviour SHALL be identical.

Verification (FW=8, DW=8, NP=2, AFULL=6)
- REQ-032 After reset, write {0x11,0x22} with i_wr_en=2'b11 -> o_wr_ack=1; next cycle o_count=2, o_rd_valid=2'b11, o_rd_data lane0=0x11, lane1=0x22.
- REQ-033 Fill to count=7, then request W=2 -> o_wr_ack=0, count stays 7, o_overflow=1 (SFIFO_ERR_EN); then request W=1 -> accepted, o_full=1.
- REQ-034 Push and pop 2 each cycle for 20 cycles starting from count=3 -> count stays 3, pointers wrap past index 7, data is read in FIFO order with no loss.
- REQ-035 At count=1, i_rd_cnt=2 -> one entry popped, o_empty=1, o_underflow=1 (SFIFO_ERR_EN).
- REQ-036 At count=5, assert i_flush together with W=2 -> next cycle count=0, no entry written; then assert i_reset -> o_underflow/o_overflow return to 0.
- REQ-037 Count crosses 5->6 -> o_afull rises in the same cycle that o_count=6.

Source files
------------

// File: rtl/sfifo_mp.sv
// Multi-port synchronous FIFO: up to NP lanes written and popped per cycle.
// Optional sticky overflow/underflow flags are enabled by defining SFIFO_ERR_EN.
module sfifo_mp #(
  parameter int unsigned FW    = 32,
  parameter int unsigned DW    = 47,
  parameter int unsigned NP    = 2,
  parameter int unsigned AFULL = FW - NP
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_flush,
  input  logic [NP-1:0]         i_wr_en,
  input  logic [NP*DW-1:0]      i_wr_data,
  output logic                  o_wr_ack,
  input  logic [$clog2(NP):0]   i_rd_cnt,
  output logic [NP-1:0]         o_rd_valid,
  output logic [NP*DW-1:0]      o_rd_data,
  output logic [$clog2(FW):0]   o_count,
`ifdef SFIFO_ERR_EN
  output logic                  o_overflow,
  output logic                  o_underflow,
`endif
  output logic                  o_empty,
  output logic                  o_full,
  output logic                  o_afull
);

  localparam int unsigned AW = $clog2(FW);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned CW = $clog2(NP) + 1;

  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PW-1:0] count_c, space_c, pop_c;
  logic [CW-1:0] wcnt_c;
  logic [NP-1:0] wlane_c;
  logic [AW-1:0] widx_c [NP];
  logic [AW-1:0] ridx_c [NP];
  logic          live_c, wr_acc_c;

  logic [DW-1:0] mem_q [FW] = '{default: '0};

  // Occupancy, acceptance and clamped pop amount, all from start-of-cycle pointers
  always_comb begin
    live_c = !i_reset && !i_flush;
    wcnt_c = '0;
    for (int k = 0; k < NP; k++) begin
      wcnt_c = wcnt_c + CW'(i_wr_en[k]);
    end
    count_c  = wptr_q - rptr_q;
    space_c  = PW'(FW) - count_c;
    wr_acc_c = live_c && (wcnt_c != '0) && (space_c >= PW'(wcnt_c));
    pop_c    = (PW'(i_rd_cnt) > count_c) ? count_c : PW'(i_rd_cnt);
    for (int k = 0; k < NP; k++) begin
      wlane_c[k] = CW'(k) < wcnt_c;
      widx_c[k]  = AW'(wptr_q + PW'(k));
      ridx_c[k]  = AW'(rptr_q + PW'(k));
    end
  end

  // Flush returns both pointers to zero and outranks any write or pop
  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (i_flush) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (wr_acc_c) wptr_d = wptr_q + PW'(wcnt_c);
      rptr_d = rptr_q + pop_c;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  // Storage is never cleared; only the pointers define what is valid
  always_ff @(posedge i_clk) begin
    for (int k = 0; k < NP; k++) begin
      if (wr_acc_c && wlane_c[k]) mem_q[widx_c[k]] <= i_wr_data[k*DW +: DW];
    end
  end

  always_comb begin
    for (int k = 0; k < NP; k++) begin
      o_rd_data[k*DW +: DW] = mem_q[ridx_c[k]];
      o_rd_valid[k]         = count_c > PW'(k);
    end
  end

  assign o_wr_ack = wr_acc_c;
  assign o_count  = count_c;
  assign o_empty  = (count_c == '0);
  assign o_full   = (count_c == PW'(FW));
  assign o_afull  = (count_c >= PW'(AFULL));

`ifdef SFIFO_ERR_EN
  logic ovf_q, unf_q;

  // Sticky error flags; only reset clears them
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else if (live_c) begin
      if ((wcnt_c != '0) && !wr_acc_c) ovf_q <= 1'b1;
      if (PW'(i_rd_cnt) > count_c)     unf_q <= 1'b1;
    end
  end

  assign o_overflow  = ovf_q;
  assign o_underflow = unf_q;
`endif

endmodule
